// File: rtl/ubc_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : ubc_cmd_seq
// Purpose  : Command sequencer driving ubc go_data/load/enable/inc for
//            LOAD / UP / DOWN / HOLD commands of bounded cycle length.
// Revision : 1.0 - initial release
// ============================================================================
module ubc_cmd_seq #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_arg,
    input  logic          abort,
    output logic [W-1:0]  go_data,
    output logic          load,
    output logic          enable,
    output logic          inc,
    output logic          busy,
    output logic          done,
    output logic          aborted
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_HOLD = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic [W-1:0]  go_data_q, go_data_d;
    logic          abort_q, abort_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        go_data_d = go_data_q;
        abort_d   = abort_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d  = cmd_op;
                    cnt_d = cmd_arg;
                    if (cmd_op == OP_LOAD) begin
                        // go_data is registered here so it is already valid in LOAD
                        go_data_d = cmd_arg[W-1:0];
                        state_d   = ST_LOAD;
                    end else if (cmd_arg == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_LOAD: state_d = ST_DONE;
            ST_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= 2'b00;
            go_data_q <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            go_data_q <= go_data_d;
            abort_q   <= abort_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign load      = (state_q == ST_LOAD);
    assign enable    = (state_q == ST_RUN) && (op_q != OP_HOLD);
    assign inc       = (state_q == ST_RUN) && (op_q == OP_UP);
    assign done      = (state_q == ST_DONE);
    assign aborted   = (state_q == ST_DONE) && abort_q;
    assign go_data   = go_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ubc_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ubc_cmd_seq
// Purpose  : Vector-table and directed-sequence bench for ubc_cmd_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ubc_cmd_seq;

    localparam logic [1:0] OP_L = 2'b00, OP_U = 2'b01, OP_D = 2'b10, OP_H = 2'b11;
    // {load, enable, inc, busy, done, aborted, cmd_ready}
    localparam logic [6:0] O_IDLE = 7'b0000001;
    localparam logic [6:0] O_LOAD = 7'b1001000;
    localparam logic [6:0] O_UP   = 7'b0111000;
    localparam logic [6:0] O_DN   = 7'b0101000;
    localparam logic [6:0] O_HOLD = 7'b0001000;
    localparam logic [6:0] O_DONE = 7'b0001100;
    localparam logic [6:0] O_ABRT = 7'b0001110;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_arg = 8'h00;
    logic       abort = 1'b0;
    logic       cmd_ready, load, enable, inc, busy, done, aborted;
    logic [3:0] go_data;
    logic [6:0] outs;

    int checks = 0;
    int errors = 0;

    ubc_cmd_seq #(.W(4), .CW(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort), .go_data(go_data),
        .load(load), .enable(enable), .inc(inc), .busy(busy), .done(done),
        .aborted(aborted)
    );

    always #5 clk = ~clk;
    assign outs = {load, enable, inc, busy, done, aborted, cmd_ready};

    // Reference counter standing in for the downstream ubc
    logic [3:0] mdl = 4'h0;
    int en_cnt = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        if (load)        mdl <= go_data;
        else if (enable) mdl <= inc ? mdl + 4'd1 : mdl - 4'd1;
        if (enable) en_cnt <= en_cnt + 1;
        if (done)   done_cnt <= done_cnt + 1;
    end

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [7:0] arg;
        logic       ab;
        logic [6:0] o;
        logic [3:0] go;
        int         m;
    } vec_t;

    vec_t vec[$];

    function automatic vec_t mk(logic v, logic [1:0] op, logic [7:0] arg, logic ab,
                                logic [6:0] o, logic [3:0] go, int m);
        vec_t r;
        r.v = v; r.op = op; r.arg = arg; r.ab = ab; r.o = o; r.go = go; r.m = m;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    initial begin
        // m < 0 means the counter model is not checked on that row
        vec.push_back(mk(1, OP_L, 8'h08, 0, O_LOAD, 4'h8, -1));
        vec.push_back(mk(0, OP_L, 8'h00, 1, O_DONE, 4'h8,  8));
        vec.push_back(mk(0, OP_L, 8'h00, 1, O_IDLE, 4'h8, -1));
        vec.push_back(mk(1, OP_L, 8'h02, 0, O_LOAD, 4'h2, -1));
        vec.push_back(mk(0, OP_L, 8'h00, 0, O_DONE, 4'h2,  2));
        vec.push_back(mk(0, OP_L, 8'h00, 0, O_IDLE, 4'h2, -1));
        vec.push_back(mk(1, OP_U, 8'd3,  0, O_UP,   4'h2, -1));
        vec.push_back(mk(0, OP_U, 8'd0,  0, O_UP,   4'h2, -1));
        vec.push_back(mk(0, OP_U, 8'd0,  0, O_UP,   4'h2, -1));
        vec.push_back(mk(0, OP_U, 8'd0,  0, O_DONE, 4'h2,  5));
        vec.push_back(mk(0, OP_U, 8'd0,  0, O_IDLE, 4'h2,  5));
        vec.push_back(mk(1, OP_L, 8'h02, 0, O_LOAD, 4'h2, -1));
        vec.push_back(mk(0, OP_L, 8'h00, 0, O_DONE, 4'h2,  2));
        vec.push_back(mk(0, OP_L, 8'h00, 0, O_IDLE, 4'h2, -1));
        // DOWN 5 with cmd_valid held: extra offers during RUN/DONE are dropped
        vec.push_back(mk(1, OP_D, 8'd5,  0, O_DN,   4'h2, -1));
        for (int i = 0; i < 4; i++) vec.push_back(mk(1, OP_D, 8'd5, 0, O_DN, 4'h2, -1));
        vec.push_back(mk(1, OP_D, 8'd5,  0, O_DONE, 4'h2, 13));
        vec.push_back(mk(1, OP_D, 8'd5,  0, O_IDLE, 4'h2, 13));
        vec.push_back(mk(1, OP_H, 8'd4,  0, O_HOLD, 4'h2, -1));
        for (int i = 0; i < 3; i++) vec.push_back(mk(0, OP_H, 8'd0, 0, O_HOLD, 4'h2, 13));
        vec.push_back(mk(0, OP_H, 8'd0,  0, O_DONE, 4'h2, 13));
        vec.push_back(mk(0, OP_H, 8'd0,  0, O_IDLE, 4'h2, -1));
        vec.push_back(mk(1, OP_U, 8'd0,  0, O_DONE, 4'h2, 13));
        vec.push_back(mk(0, OP_U, 8'd0,  0, O_IDLE, 4'h2, 13));

        #1;
        chk("reset_outs", int'(outs), int'(O_IDLE));
        chk("reset_go_data", int'(go_data), 0);
        #11 reset = 1'b0;
        tick;
        chk("post_reset_outs", int'(outs), int'(O_IDLE));

        for (int i = 0; i < vec.size(); i++) begin
            cmd_valid = vec[i].v;
            cmd_op    = vec[i].op;
            cmd_arg   = vec[i].arg;
            abort     = vec[i].ab;
            tick;
            chk($sformatf("row%0d_outs", i), int'(outs), int'(vec[i].o));
            chk($sformatf("row%0d_go_data", i), int'(go_data), int'(vec[i].go));
            if (vec[i].m >= 0) chk($sformatf("row%0d_ubc", i), int'(mdl), vec[i].m);
        end

        begin : abort_seq
            int base;
            cmd_valid = 1'b1; cmd_op = OP_U; cmd_arg = 8'd200; abort = 1'b0;
            tick;
            chk("abort_run1", int'(outs), int'(O_UP));
            base = en_cnt;
            tick;
            tick;
            chk("abort_run3", int'(outs), int'(O_UP));
            abort = 1'b1;
            tick;
            chk("abort_done", int'(outs), int'(O_ABRT));
            abort = 1'b0;
            tick;
            chk("abort_idle", int'(outs), int'(O_IDLE));
            chk("abort_enable_cycles", en_cnt - base, 3);
            chk("abort_ubc", int'(mdl), 0);
        end

        begin : reset_seq
            int dbase;
            tick;
            chk("held_valid_accept", int'(outs), int'(O_UP));
            tick;
            dbase = done_cnt;
            #2 reset = 1'b1;
            #1;
            chk("async_reset_outs", int'(outs), int'(O_IDLE));
            chk("async_reset_go_data", int'(go_data), 0);
            cmd_valid = 1'b0;
            tick;
            chk("reset_held_outs", int'(outs), int'(O_IDLE));
            reset = 1'b0;
            chk("reset_no_done", done_cnt - dbase, 0);
            cmd_valid = 1'b1; cmd_op = OP_L; cmd_arg = 8'h05;
            tick;
            chk("after_reset_load", int'(outs), int'(O_LOAD));
            chk("after_reset_go_data", int'(go_data), 5);
            cmd_valid = 1'b0;
            tick;
            chk("after_reset_done", int'(outs), int'(O_DONE));
            chk("after_reset_ubc", int'(mdl), 5);
            tick;
            chk("after_reset_idle", int'(outs), int'(O_IDLE));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ubc_cmd_seq.md
Name: ubc_cmd_seq

Overview:
Command sequencer that sits directly upstream of the universal binary counter (ubc) and drives its go_data/load/enable/inc inputs. It accepts one command per valid/ready handshake: load a value, count up N cycles, count down N cycles, or hold N cycles. It then runs the counter control pins for exactly the commanded duration and pulses done. This replaces hand-sequenced control stimulus with a deterministic, bounded command interface.

Parameters:
W, 4, counter data width (matches ubc go_data/get_data).
CW, 8, command argument / cycle-count width; must satisfy CW >= W.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command offered.
cmd_ready  output  1  sequencer can accept a command.
cmd_op  input  2  00=LOAD, 01=UP, 10=DOWN, 11=HOLD.
cmd_arg  input  CW  LOAD: value in bits [W-1:0]; UP/DOWN/HOLD: cycle count N.
abort  input  1  synchronous; terminates an in-progress RUN.
go_data  output  W  to ubc go_data.
load  output  1  to ubc load.
enable  output  1  to ubc enable.
inc  output  1  to ubc inc (1=up, 0=down).
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse at end of every command.
aborted  output  1  valid with done; 1 if the command ended by abort.

Behaviour:
- Reset (async, immediate): state=IDLE, cnt=0, op_q=0, go_data=0, load=0, enable=0, inc=0, done=0, aborted=0, busy=0, cmd_ready=1.
- All outputs are Moore functions of registered state, op_q, arg_q and cnt. There is no combinational path from the cmd_*/abort inputs to any output.
- States: IDLE, LOAD, RUN, DONE.
- IDLE: cmd_ready=1. On a rising edge with cmd_valid=1, capture op_q=cmd_op and arg_q=cmd_arg, and load cnt=cmd_arg. Next state:
  - LOAD if op=LOAD.
  - DONE if op≠LOAD and cmd_arg=0 (zero-length command; no enable cycle issued).
  - RUN otherwise.
- LOAD: exactly 1 cycle. load=1, enable=0, go_data=arg_q[W-1:0]. Next state is DONE.
- RUN:
  - enable=1 for UP/DOWN and 0 for HOLD; inc=1 for UP and 0 for DOWN/HOLD.
  - cnt decrements by 1 each cycle. When cnt=1, next state is DONE, so RUN lasts exactly N cycles (N up to 2^CW-1).
- abort in RUN: next state is DONE and aborted is set. Outputs in that abort cycle are still the RUN values. abort is ignored in IDLE, LOAD and DONE.
- DONE: exactly 1 cycle. done=1, aborted=abort flag, load=enable=inc=0, cmd_ready=0. Next state is IDLE and the abort flag clears.
- Throughput: back-to-back commands are possible. A command accepted in cycle t0 is followed by the next accept at earliest t0+3 (LOAD or N=1), or t0+N+2.
- go_data holds the last loaded value outside LOAD. The counter ignores it unless load=1.
- Outside IDLE, cmd_valid is ignored (not queued).
- Reset asserted mid-command aborts immediately to the reset values with no done pulse.
- busy=1 in LOAD, RUN and DONE.

Test Plan:
1. Reset released; cmd LOAD arg=0x08 -> next cycle load=1, go_data=1000; following cycle done=1, aborted=0; then cmd_ready=1.
2. UP N=3 after LOAD 0x02 -> enable=1, inc=1 for exactly 3 cycles; ubc get_data 0010→0101; done one cycle after the last enable.
3. DOWN N=5 from 0x02 -> inc=0, enable=1 for 5 cycles; ubc wraps to 1101; then done=1.
4. HOLD N=4 -> enable=0 for 4 cycles, get_data unchanged, busy=1 throughout; UP N=0 -> no enable cycle, done on the cycle after accept.
5. UP N=200, abort pulsed in the 3rd RUN cycle -> exactly 3 enable cycles, then done=1 with aborted=1; cmd_valid held high during RUN is not accepted until IDLE.
6. reset asserted asynchronously mid-RUN (between clk edges) -> enable/inc/busy drop immediately with no done pulse; the first command after release is accepted normally.
